// File: rtl/seqdect_pkg.sv
// Shared types and constants for the seqdect round-robin scheduler.
package seqdect_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DET_LAT = 1;
  localparam int unsigned DEF_CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Ceiling log2, never below 1 so single-value fields still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seqdect_rr_arb.sv
// Round-robin arbiter: picks the first request at or after its own pointer
// and advances the pointer past the winner when the grant is taken.
module seqdect_rr_arb
  import seqdect_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned ID_W = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  localparam int unsigned SW = ID_W + 1;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [2*NREQ-1:0] rot;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     nxt;

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    rot = {req, req} >> ptr;
    any = 1'b0;
    id  = '0;
    sum = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!any && rot[0]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + SW'(off);
        if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
        id = ID_W'(sum);
      end
      rot = rot >> 1;
    end
    gnt = (en && any) ? (NREQ'(1) << id) : '0;
    nxt = {1'b0, id} + SW'(1);
    ptr_nxt = (nxt == SW'(NREQ)) ? '0 : ID_W'(nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/seqdect_sched.sv
// Shares one serial sequence detector among NREQ requesters: grants a frame,
// clears the detector, shifts the frame MSB-first and reports the hit count.
module seqdect_sched
  import seqdect_pkg::*;
#(
  parameter  int unsigned NREQ    = DEF_NREQ,
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned DET_LAT = DEF_DET_LAT,
  parameter  int unsigned CNT_W   = DEF_CNT_W,
  localparam int unsigned ID_W    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic                  det_rst,
  output logic                  prtx,
  input  logic                  prtz
);

  localparam int unsigned CNT_BITS = clog2(WIDTH + DET_LAT + 1);
  localparam logic [CNT_BITS-1:0] SHIFT_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'(DET_LAT - 1);

  state_t              state;
  state_t              state_next;
  logic                arb_en;
  logic                arb_any;
  logic [ID_W-1:0]     arb_id;
  logic [WIDTH-1:0]    sreg;
  logic [CNT_BITS-1:0] cnt;

  seqdect_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req  (req),
    .gnt  (gnt),
    .id   (arb_id),
    .any  (arb_any)
  );

  assign det_rst = rst | (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arb_en     = 1'b0;
    case (state)
      IDLE: begin
        arb_en = !rst;
        if (arb_any) state_next = CLEAR;
      end
      CLEAR:  state_next = SHIFT;
      SHIFT:  if (cnt == SHIFT_LAST) state_next = DRAIN;
      DRAIN:  if (cnt == DRAIN_LAST) state_next = REPORT;
      REPORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      hit_cnt <= '0;
      prtx    <= 1'b0;
      sreg    <= '0;
      cnt     <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == REPORT);
      prtx <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            sreg    <= WIDTH'(data >> (32'(arb_id) * WIDTH));
            done_id <= arb_id;
          end
        end
        CLEAR: begin
          hit_cnt <= '0;
          cnt     <= '0;
        end
        SHIFT, DRAIN: begin
          cnt <= (state == SHIFT && state_next == DRAIN) ? '0 : cnt + CNT_BITS'(1);
          if (prtz && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
      if (state_next == SHIFT) begin
        prtx <= sreg[WIDTH-1];
        sreg <= sreg << 1;
      end
    end
  end

endmodule

// File: tb/tb_seqdect_sched.sv
// Self-checking bench for seqdect_sched with a behavioural overlapping "101"
// Moore detector (one cycle latency) attached to each scheduler instance.
module tb_seqdect_sched;

  typedef struct {
    int id;
    int hits;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy, done, det_rst, prtx, prtz;
  logic [1:0]  done_id;
  logic [3:0]  hit_cnt;

  logic [3:0]  req_s;
  logic [31:0] data_s;
  logic [3:0]  gnt_s;
  logic        busy_s, done_s, det_rst_s, prtx_s, prtz_s;
  logic [1:0]  done_id_s;
  logic [0:0]  hit_s;

  logic [1:0]  dq, dq_s;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        sb_s[$];

  seqdect_sched dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .det_rst(det_rst),
    .prtx(prtx), .prtz(prtz)
  );

  seqdect_sched #(.CNT_W(1)) dut_s (
    .clk(clk), .rst(rst), .req(req_s), .data(data_s), .gnt(gnt_s), .busy(busy_s),
    .done(done_s), .done_id(done_id_s), .hit_cnt(hit_s), .det_rst(det_rst_s),
    .prtx(prtx_s), .prtz(prtz_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector states: 0 idle, 1 seen "1", 2 seen "10", 3 seen "101".
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
    case (s)
      2'd0:    return x ? 2'd1 : 2'd0;
      2'd1:    return x ? 2'd1 : 2'd2;
      2'd2:    return x ? 2'd3 : 2'd0;
      default: return x ? 2'd1 : 2'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    dq   <= det_rst   ? 2'd0 : det_next(dq, prtx);
    dq_s <= det_rst_s ? 2'd0 : det_next(dq_s, prtx_s);
  end
  assign prtz   = (dq == 2'd3);
  assign prtz_s = (dq_s == 2'd3);

  function automatic int model_hits(input logic [7:0] f, input int cw);
    int c;
    logic [2:0] w;
    c = 0;
    for (int i = 0; i <= 5; i++) begin
      w = f[7-i -: 3];
      if (w == 3'b101) c++;
    end
    if (c > (1 << cw) - 1) c = (1 << cw) - 1;
    return c;
  endfunction

  function automatic logic [7:0] frame_of(input int i);
    return data[i*8 +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; req_s = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      #1;
      if (gnt !== 4'b0000) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL gnt_timeout: no grant within %0d cycles, req=%b", limit, req);
    end
  endtask

  // Entered in the grant cycle; follows the frame through its REPORT cycle.
  task automatic frame_watch(input int id, input logic [3:0] req_next, input logic [7:0] frame);
    exp_t e;
    logic [7:0] bits;
    int early_done;
    bit bad_busy, bad_prtx, bad_gnt;
    #1;
    n_checks++;
    if (gnt !== (4'b0001 << id)) begin
      n_fail++; $display("FAIL grant_id: gnt=%b expected=%b", gnt, 4'b0001 << id);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_idle: busy=%b expected=0 in grant cycle", busy);
    end
    e.id = id; e.hits = model_hits(frame, 4); sb.push_back(e);
    bits = '0; early_done = 0; bad_busy = 0; bad_prtx = 0; bad_gnt = 0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = req_next;
        n_checks++;
        if (det_rst !== 1'b1) begin
          n_fail++; $display("FAIL det_rst_clear: det_rst=%b expected=1", det_rst);
        end
      end
      if (busy !== 1'b1) bad_busy = 1;
      if (gnt !== 4'b0000) bad_gnt = 1;
      if (n >= 2 && n <= 9) bits[9-n] = prtx;
      else if (prtx !== 1'b0) bad_prtx = 1;
      if (n < 11 && done === 1'b1) early_done++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL done_timing: done=%b expected=1 eleven cycles after gnt", done);
    end
    e = sb.pop_front();
    n_checks++;
    if (done_id !== 2'(e.id)) begin
      n_fail++; $display("FAIL done_id: got=%0d expected=%0d", done_id, e.id);
    end
    n_checks++;
    if (hit_cnt !== 4'(e.hits)) begin
      n_fail++; $display("FAIL hit_cnt: got=%0d expected=%0d frame=%h", hit_cnt, e.hits, frame);
    end
    n_checks++;
    if (bits !== frame) begin
      n_fail++; $display("FAIL prtx_serial: got=%b expected=%b", bits, frame);
    end
    n_checks++;
    if ({bad_busy, bad_prtx, bad_gnt} !== 3'b000 || early_done != 0) begin
      n_fail++;
      $display("FAIL frame_ctrl: busy_bad=%b prtx_bad=%b gnt_bad=%b early_done=%0d expected all 0",
               bad_busy, bad_prtx, bad_gnt, early_done);
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    rst = 1'b1; req = 4'b1111; req_s = '0; data = '0; data_s = '0;
    repeat (2) @(negedge clk);
    #1;
    obs = {gnt, busy, done, done_id, hit_cnt, prtx, det_rst};
    n_checks++;
    if (obs !== 14'b0000_0_0_00_0000_0_1) begin
      n_fail++; $display("FAIL reset_state: got=%b expected=%b", obs, 14'b0000_0_0_00_0000_0_1);
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    data = 32'h0000_00AA; req = 4'b0001;
    frame_watch(0, 4'b0000, 8'hAA);
  endtask

  task automatic test_zero();
    bit ok;
    data = 32'h0000_0000; req = 4'b0001;
    wait_gnt(20, ok);
    if (ok) frame_watch(0, 4'b0000, 8'h00);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev;
    do_reset();
    data = {8'h55, 8'h2D, 8'hFF, 8'hB5}; req = 4'b1111;
    wait_gnt(20, ok);
    prev = cyc;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) begin
        @(negedge clk);
        n_checks++;
        if (cyc - prev != 12) begin
          n_fail++; $display("FAIL gnt_period: got=%0d expected=12", cyc - prev);
        end
        prev = cyc;
      end
      frame_watch(f % 4, 4'b1111, frame_of(f % 4));
    end
    req = '0;
  endtask

  task automatic test_saturate();
    exp_t e;
    bit got;
    do_reset();
    data_s = 32'h0000_00AA; req_s = 4'b0001;
    e.id = 0; e.hits = model_hits(8'hAA, 1); sb_s.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) req_s = '0;
      if (done_s === 1'b1) begin got = 1'b1; break; end
    end
    e = sb_s.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL sat_timeout: done never seen on CNT_W=1 instance");
    end
    n_checks++;
    if ({done_id_s, hit_s} !== {2'(e.id), 1'(e.hits)}) begin
      n_fail++; $display("FAIL sat_hit_cnt: id=%0d hits=%0d expected id=%0d hits=%0d",
                         done_id_s, hit_s, e.id, e.hits);
    end
  endtask

  task automatic test_rst_mid_frame();
    bit ok;
    int dones;
    logic [7:0] obs;
    do_reset();
    data = {8'h00, 8'hB5, 8'hAA, 8'h00}; req = 4'b0100;
    wait_gnt(20, ok);
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL rst_first_gnt: gnt=%b expected=0100", gnt);
    end
    @(negedge clk); req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    obs = {prtx, busy, det_rst, done, gnt};
    n_checks++;
    if (obs !== 8'b0010_0000) begin
      n_fail++; $display("FAIL rst_abort: {prtx,busy,det_rst,done,gnt}=%b expected=00100000", obs);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL rst_no_done: got %0d done/busy cycles expected=0", dones);
    end
    req = 4'b0110;
    wait_gnt(20, ok);
    if (ok) frame_watch(1, 4'b0000, 8'hAA);
  endtask

  task automatic test_withdraw();
    bit ok;
    int stray;
    do_reset();
    data = {8'hFF, 8'h00, 8'h55, 8'h00}; req = 4'b1010;
    wait_gnt(20, ok);
    if (ok) frame_watch(1, 4'b0010, 8'h55);
    @(negedge clk);
    frame_watch(1, 4'b0000, 8'h55);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000 || done === 1'b1) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++; $display("FAIL withdraw: got %0d stray grant/done cycles expected=0", stray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_saturate();
    test_rst_mid_frame();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
